led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
- Output-side counterpart of the capacitive-sense input path.
- Takes per-button on/off levels (e.g. the sampled or toggled capsense button vector) and drives one LED pin per channel.
- Each channel fades in or out with a shared PWM counter and a shared fade-tick prescaler.
- Sits between the capsense system block and the board led pins.

Parameters:
- N, 4: number of channels.
- PWM_BITS, 8: PWM counter and brightness width; MAX = 2^PWM_BITS-1.
- FADE_DIV, 24000: clocks per fade tick; must be at least 1.
- STEP, 16: brightness change per fade tick; range 1..MAX.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  synchronous reset, active low.
- level_i  in  N  target per channel (1 = lit); sampled every clock; no synchroniser inside.
- led_o  out  N  PWM LED drive, registered.
- busy_o  out  1  registered; 1 while any channel is in RISE or FALL.
- bright_o  out  N*PWM_BITS  current brightness; channel i at bits [i*PWM_BITS +: PWM_BITS].

Behaviour:
- Reset: when rst_ni=0 at a clock edge, the following all go to 0:
  - pwm counter
  - prescaler
  - all brightness values
  - led_o, busy_o
  - every channel FSM goes to OFF.
  - Reset mid-fade aborts immediately; no further ticks occur until release.
- Prescaler:
  - Counts 0..FADE_DIV-1, then wraps to 0.
  - tick = (prescaler == FADE_DIV-1), combinational, one clock wide.
  - First tick falls on the FADE_DIV-th clock after reset release.
- PWM counter: free-running PWM_BITS-wide counter, wraps MAX->0.
- Per-channel FSM, states OFF, RISE, ON, FALL. Transitions are evaluated every clock:
  - OFF: level=1 -> RISE.
  - RISE: level=0 -> FALL. On a tick with level=1: bright += STEP, saturating at MAX; if the result is MAX -> ON.
  - ON: level=0 -> FALL.
  - FALL: level=1 -> RISE. On a tick with level=0: bright -= STEP, saturating at 0; if the result is 0 -> OFF.
  - Direction reversal mid-fade keeps the current brightness; there is no jump.
  - A level change and a tick in the same clock: the state change wins, and brightness is not modified that clock.
- Brightness arithmetic:
  - Computed at PWM_BITS+1 width, then clamped.
  - No wrap-around is permitted at either end.
- led_o:
  - Registered compare: led_o[i] <= (duty_i == MAX) | (duty_i > pwm counter).
  - So duty 0 is constant 0, and MAX is constant 1.
  - Latency: one clock from the counter/duty value to the pin.
- busy_o: registered OR over channels of (state == RISE or state == FALL).

Optional Feature:
- Macro LED_FADE_GAMMA_EN.
- Defined:
  - duty_i = (bright_i * bright_i) >> PWM_BITS, except bright_i == MAX gives duty MAX.
  - Product computed at 2*PWM_BITS width.
  - bright_o still reports the linear value.
- Undefined: duty_i = bright_i.
- FSM and timing are identical either way.

Decomposition:
- Package led_fade_pkg contains:
  - the state enum (OFF=0, RISE=1, ON=2, FALL=3, 2-bit);
  - the function for saturating add/sub;
  - the gamma function.
- Sub-module led_fade_chan: one channel FSM plus brightness register plus duty/compare.
  - Inputs: clk_i, rst_ni, level, tick, pwm count.
  - Outputs: led, bright, busy.
  - Instantiated N times by a generate loop.
- Top owns the prescaler, the PWM counter, and the busy_o OR-reduction.

Test Plan:
- Config for all scenarios: N=4, PWM_BITS=8, FADE_DIV=4, STEP=16, macro off.
- 1. Reset: hold rst_ni=0 for 3 clocks with level_i=4'hF.
  - During reset: led_o=0, busy_o=0, all bright=0.
  - After release: first increment of ch0-3 to 16 occurs on the 4th clock edge.
- 2. Full rise: level_i[0]=1 held.
  - bright0 steps 0,16,…,240, then 255 (clamped) after 16 ticks (64 clocks).
  - State ON; busy_o drops to 0 one clock after.
  - led_o[0] is constant 1 thereafter.
- 3. Reversal: at bright0=128, drop level_i[0].
  - No jump; next tick gives 112.
  - Reaches 0 after 8 ticks total from 128; state OFF.
  - led_o[0] is constant 0.
- 4. Coincident event: toggle level_i[1] 0->1 in the same clock as a tick while OFF.
  - Brightness stays 0 that clock.
  - Becomes 16 only on the following tick.
- 5. PWM duty: freeze ch2 at bright=64 (level held through a RISE to 64, then FSM held via level toggling).
  - Over 256 clocks, led_o[2] is high exactly 64 cycles.
- 6. Gamma with the macro defined: bright=128.
  - duty=64; led_o high 64 of 256 clocks.
  - bright=255 gives led_o constant 1.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared types and arithmetic helpers for the LED fade driver.
// Channel states plus saturating brightness steps and the squared-duty gamma curve.
package led_fade_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } fade_state_e;

    // Operands are at most PWM_BITS wide, so 32 bits always holds the one-bit-wider sum.
    function automatic int unsigned sat_add(input int unsigned val,
                                            input int unsigned step,
                                            input int unsigned max_val);
        int unsigned sum;
        sum = val + step;
        return (sum > max_val) ? max_val : sum;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned val,
                                            input int unsigned step);
        return (val < step) ? 32'd0 : (val - step);
    endfunction

    // Square-law duty with full scale pinned so a fully lit LED never flickers.
    function automatic int unsigned gamma_duty(input int unsigned bright,
                                               input int unsigned bits);
        int unsigned max_val;
        max_val = (32'd1 << bits) - 32'd1;
        if (bright == max_val)
            return max_val;
        return (bright * bright) >> bits;
    endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: fade FSM, brightness register and registered PWM compare.
// Define LED_FADE_GAMMA_EN to drive the pin from a squared brightness curve.
module led_fade_chan
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                level_i,
    input  logic                tick_i,
    input  logic [PWM_BITS-1:0] pwm_i,
    output logic                led_o,
    output logic [PWM_BITS-1:0] bright_o,
    output logic                busy_o
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    fade_state_e         r_state;
    logic [PWM_BITS-1:0] r_bright;
    logic                r_led;
    logic [PWM_BITS-1:0] w_up;
    logic [PWM_BITS-1:0] w_dn;
    logic [PWM_BITS-1:0] w_duty;

    assign w_up = PWM_BITS'(sat_add(32'(r_bright), 32'(STEP), 32'(MAX)));
    assign w_dn = PWM_BITS'(sat_sub(32'(r_bright), 32'(STEP)));

`ifdef LED_FADE_GAMMA_EN
    assign w_duty = PWM_BITS'(gamma_duty(32'(r_bright), 32'(PWM_BITS)));
`else
    assign w_duty = r_bright;
`endif

    // A level change always takes priority over a tick arriving in the same clock.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= OFF;
            r_bright <= '0;
            r_led    <= 1'b0;
        end else begin
            r_led <= (w_duty == MAX) || (w_duty > pwm_i);
            case (r_state)
                OFF: begin
                    if (level_i)
                        r_state <= RISE;
                end
                RISE: begin
                    if (!level_i) begin
                        r_state <= FALL;
                    end else if (tick_i) begin
                        r_bright <= w_up;
                        if (w_up == MAX)
                            r_state <= ON;
                    end
                end
                ON: begin
                    if (!level_i)
                        r_state <= FALL;
                end
                FALL: begin
                    if (level_i) begin
                        r_state <= RISE;
                    end else if (tick_i) begin
                        r_bright <= w_dn;
                        if (w_dn == '0)
                            r_state <= OFF;
                    end
                end
                default: r_state <= OFF;
            endcase
        end
    end

    assign led_o    = r_led;
    assign bright_o = r_bright;
    assign busy_o   = (r_state == RISE) || (r_state == FALL);

endmodule

// File: rtl/led_fade_driver.sv
// Multi-channel LED fader: shared fade-tick prescaler and PWM counter feeding N channels.
// Optional square-law brightness is selected in the channels by LED_FADE_GAMMA_EN.
module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int N        = 4,
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 24000,
    parameter int STEP     = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N-1:0]          level_i,
    output logic [N-1:0]          led_o,
    output logic                  busy_o,
    output logic [N*PWM_BITS-1:0] bright_o
);

    localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [PRE_W-1:0]    r_pre;
    logic [PWM_BITS-1:0] r_pwm;
    logic                r_busy;
    logic                w_tick;
    logic [N-1:0]        w_busy;

    assign w_tick = (r_pre == PRE_W'(FADE_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pre  <= '0;
            r_pwm  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_pre  <= w_tick ? '0 : r_pre + 1'b1;
            r_pwm  <= r_pwm + 1'b1;
            r_busy <= |w_busy;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            led_fade_chan #(
                .PWM_BITS (PWM_BITS),
                .STEP     (STEP)
            ) u_chan (
                .clk_i    (clk_i),
                .rst_ni   (rst_ni),
                .level_i  (level_i[gi]),
                .tick_i   (w_tick),
                .pwm_i    (r_pwm),
                .led_o    (led_o[gi]),
                .bright_o (bright_o[gi*PWM_BITS +: PWM_BITS]),
                .busy_o   (w_busy[gi])
            );
        end
    endgenerate

    assign busy_o = r_busy;

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver: directed fade scenarios followed by random level traffic,
// each clock compared against a goal/settled brightness model.
module tb_led_fade_driver;

    localparam int N    = 4;
    localparam int PB   = 8;
    localparam int FD   = 4;
    localparam int ST   = 16;
    localparam int MAXV = 255;

    logic            clk_i   = 1'b0;
    logic            rst_ni  = 1'b0;
    logic [N-1:0]    level_i = '0;
    logic [N-1:0]    led_o;
    logic            busy_o;
    logic [N*PB-1:0] bright_o;

    always #5 clk_i = ~clk_i;

    led_fade_driver #(
        .N        (N),
        .PWM_BITS (PB),
        .FADE_DIV (FD),
        .STEP     (ST)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .level_i  (level_i),
        .led_o    (led_o),
        .busy_o   (busy_o),
        .bright_o (bright_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: each channel has a goal (0 or 1) and a flag saying the goal has been reached.
    int           m_b    [N];
    bit           m_aim  [N];
    bit           m_done [N];
    int           m_k;
    logic [N-1:0] exp_led;
    logic         exp_busy;

    function automatic int duty_of(input int b);
`ifdef LED_FADE_GAMMA_EN
        return (b == MAXV) ? MAXV : (b * b) >> PB;
`else
        return b;
`endif
    endfunction

    function automatic logic [31:0] exp_bright();
        logic [31:0] v;
        v = '0;
        for (int c = 0; c < N; c++)
            v[c*PB +: PB] = 8'(m_b[c]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_edge();
        bit tick;
        if (!rst_ni) begin
            m_k      = 0;
            exp_led  = '0;
            exp_busy = 1'b0;
            for (int c = 0; c < N; c++) begin
                m_b[c] = 0; m_aim[c] = 1'b0; m_done[c] = 1'b1;
            end
        end else begin
            m_k++;
            tick     = (m_k % FD) == 0;
            exp_busy = 1'b0;
            for (int c = 0; c < N; c++) begin
                exp_led[c] = (duty_of(m_b[c]) == MAXV) || (duty_of(m_b[c]) > ((m_k - 1) % 256));
                if (!m_done[c]) exp_busy = 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                if (level_i[c] != m_aim[c]) begin
                    m_aim[c]  = level_i[c];
                    m_done[c] = 1'b0;
                end else if (!m_done[c] && tick) begin
                    if (m_aim[c]) m_b[c] = (m_b[c] + ST > MAXV) ? MAXV : m_b[c] + ST;
                    else          m_b[c] = (m_b[c] < ST) ? 0 : m_b[c] - ST;
                    m_done[c] = (m_b[c] == (m_aim[c] ? MAXV : 0));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
        check("bright", 32'(bright_o), exp_bright());
        check("led", 32'(led_o), 32'(exp_led));
        check("busy", 32'(busy_o), 32'(exp_busy));
    endtask

    task automatic do_reset(input int cycles, input logic [N-1:0] lvl);
        rst_ni  = 1'b0;
        level_i = lvl;
        repeat (cycles) step();
        rst_ni = 1'b1;
    endtask

    function automatic logic [31:0] br(input int c);
        return 32'(bright_o[c*PB +: PB]);
    endfunction

    int hi_cnt;

    initial begin
        // Reset held with all levels high, then first increment on the 4th edge.
        rst_ni  = 1'b0;
        level_i = 4'hF;
        repeat (3) begin
            step();
            check("rst_led", 32'(led_o), 32'd0);
            check("rst_busy", 32'(busy_o), 32'd0);
            check("rst_bright", 32'(bright_o), 32'd0);
        end
        rst_ni = 1'b1;
        repeat (3) step();
        check("pre_tick_bright", 32'(bright_o), 32'd0);
        step();
        check("first_tick_bright", 32'(bright_o), 32'h10101010);

        // Full rise of channel 0.
        do_reset(2, 4'b0001);
        repeat (63) step();
        check("rise_240", br(0), 32'd240);
        step();
        check("rise_255", br(0), 32'd255);
        check("rise_busy_lag", 32'(busy_o), 32'd1);
        step();
        check("rise_busy_drop", 32'(busy_o), 32'd0);
        hi_cnt = 0;
        repeat (256) begin step(); hi_cnt += int'(led_o[0]); end
        check("on_led_const", 32'(hi_cnt), 32'd256);

        // Reversal at 128.
        do_reset(2, 4'b0001);
        repeat (32) step();
        check("rev_128", br(0), 32'd128);
        level_i = 4'b0000;
        step();
        check("rev_no_jump", br(0), 32'd128);
        repeat (3) step();
        check("rev_112", br(0), 32'd112);
        repeat (28) step();
        check("rev_zero", br(0), 32'd0);
        hi_cnt = 0;
        repeat (256) begin step(); hi_cnt += int'(led_o[0]); end
        check("off_led_const", 32'(hi_cnt), 32'd0);
        check("off_busy", 32'(busy_o), 32'd0);

        // Level rises on the same clock as a tick.
        do_reset(2, 4'b0000);
        repeat (3) step();
        level_i = 4'b0010;
        step();
        check("coinc_hold", br(1), 32'd0);
        repeat (3) step();
        check("coinc_wait", br(1), 32'd0);
        step();
        check("coinc_16", br(1), 32'd16);

        // Channel 2 frozen at 64 by toggling its level every clock.
        do_reset(2, 4'b0100);
        repeat (16) step();
        check("pwm_64", br(2), 32'd64);
        hi_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            level_i[2] = ~level_i[2];
            step();
            if (i >= 2 && i < 258) hi_cnt += int'(led_o[2]);
        end
        check("pwm_frozen", br(2), 32'd64);
        check("pwm_duty", 32'(hi_cnt), 32'(duty_of(64)));

        // Random level traffic with occasional mid-fade resets.
        do_reset(2, 4'b0000);
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(39) == 0) level_i[c] = ~level_i[c];
            rst_ni = ($urandom_range(799) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
